ram_256x16_sync: RTL and testbench
==================================

Name: ram_256x16_sync

Overview:
- Single-port 256-word x 16-bit data RAM for the single-cycle RISC datapath (data memory / scratch storage).
- Writes are synchronous on the rising clock edge; reads are combinational from the current address.
- Built from a flip-flop array so the whole array can be cleared by the asynchronous reset.

Parameters:
- ADDR_WIDTH, 8, address bits; depth = 2**ADDR_WIDTH words (256).
- DATA_WIDTH, 16, bits per word.

Ports:
- clk, input, 1, system clock; all writes occur on its rising edge.
- rst, input, 1, reset, asynchronous and active-high; clears every word to 0.
- Addr, input, ADDR_WIDTH, word address for both read and write.
- Write_En, input, 1, write enable, active-high.
- D, input, DATA_WIDTH, write data.
- O, output, DATA_WIDTH, read data: the word at Addr.

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Storage: array mem[0..255] of 16-bit words.

Reset:
- While rst=1, all 256 words are forced to 16'h0000 immediately, without waiting for clk.
- O therefore reads 16'h0000 during reset.
- Writes are ignored while rst=1.
- Reset asserted mid-operation overrides any write in progress in that cycle.

Write:
- On a rising clk edge with rst=0 and Write_En=1, mem[Addr] <= D.
- Exactly one word is modified per edge; all other words are unchanged.
- With Write_En=0, memory is unchanged regardless of D and Addr.

Read:
- O = mem[Addr], combinational (zero-cycle latency).
- O changes whenever Addr changes, with no clock required.
- O also updates after a write edge to the addressed word.

Read-during-write:
- When Write_En=1, O shows the old contents of mem[Addr] until the rising edge, then the new D.
- There is no write-through bypass before the edge.

Address range:
- Full 8-bit range 8'h00..8'hFF is valid; no wrap-around or out-of-range case exists.
- Address decode is purely combinational; no latches.

Timing and widths:
- Addr, D and Write_En are sampled only at the rising edge for writes; changes between edges have no effect on memory.
- No X propagation from unwritten locations: every location is defined after reset.
- No width extension or truncation: D and O are exactly DATA_WIDTH bits.
- Back-to-back writes to different addresses on consecutive edges are all retained.
- Rewriting the same address keeps the last value.

Test Plan:
- Reset: pulse rst=1 asynchronously between clock edges -> O=16'h0000 immediately for Addr=8'h00, 8'h12 and 8'hFF.
- Write sweep: with Write_En=1, write one word per cycle: 12:1234, 34:3456, 56:5678, 78:789A, 9A:9ABC, BC:BCDE, DE:DEF0, F0:F012.
- Read-back: then Write_En=0 and step Addr through 12,34,56,78,9A,BC,DE,F0 -> O=1234,3456,5678,789A,9ABC,BCDE,DEF0,F012, each valid combinationally without a clock edge.
- Write-enable low: Write_En=0, Addr=8'h12, D=16'hFFFF, clock 3 edges -> O stays 16'h1234; unwritten address 8'h13 reads 16'h0000.
- Read-during-write and boundaries: Addr=8'hFF, D=16'hA5A5, Write_En=1 -> O=16'h0000 before the edge, 16'hA5A5 after it; then write Addr=8'h00 D=16'h5A5A -> both ends hold their values with no aliasing.
- Reset mid-operation: after the sweep, assert rst while Write_En=1, Addr=8'h34, D=16'h1111 across an edge -> all addresses read 16'h0000 after rst deasserts; no write occurred.

Source files
------------

// File: rtl/ram_256x16_sync.sv
// ram_256x16_sync: single-port 256 x 16 data RAM for the single-cycle RISC
// datapath. Writes take effect on the rising clock edge. Reads are
// combinational from the current address. The storage is a flip-flop array,
// so the asynchronous reset can clear every word at once.

module ram_256x16_sync #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] Addr,
    input  logic                  Write_En,
    input  logic [DATA_WIDTH-1:0] D,
    output logic [DATA_WIDTH-1:0] O
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    // Storage array: one register per word.
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    // Read data for the current address.
    logic [DATA_WIDTH-1:0] w_rd_data;

    // Storage update. Reset has priority over the write, so a write that
    // lands in the same cycle as reset is dropped.
    // NOTE: every word has a reset term. That is only possible because the
    // array is built from flip-flops. A block-RAM macro could not be cleared
    // like this, and the reset loop would prevent RAM inference.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                // NOTE: sequential state uses non-blocking assignment. All
                // words then update together at the edge, with no ordering
                // race against the combinational read path.
                r_mem[i] <= '0;
            end
        end else if (Write_En) begin
            r_mem[Addr] <= D;
        end
    end

    // Combinational read mux. It has no write-through bypass: during a write
    // cycle it shows the old word until the edge commits D.
    // NOTE: a continuous assignment, or an always_comb with a default written
    // first, assigns the output on every path. That keeps the address decode
    // free of inferred latches.
    assign w_rd_data = r_mem[Addr];

    assign O = w_rd_data;

endmodule

// File: tb/tb_ram_256x16_sync.sv
// tb_ram_256x16_sync: scoreboard bench for ram_256x16_sync. A reference
// memory model supplies each expected read value. The value is queued when
// the stimulus is driven and popped when the DUT output is sampled.

module tb_ram_256x16_sync;

    logic        clk;
    logic        rst;
    logic [7:0]  Addr;
    logic        Write_En;
    logic [15:0] D;
    logic [15:0] O;

    logic [15:0] model [256];
    logic [15:0] exp_q [$];
    logic [15:0] exp_v;
    int          total;
    int          bad;

    ram_256x16_sync #(
        .ADDR_WIDTH(8),
        .DATA_WIDTH(16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .Addr     (Addr),
        .Write_En (Write_En),
        .D        (D),
        .O        (O)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Asynchronous reset pulse issued between edges. O must read zero
    // immediately, with no clock edge.
    task automatic test_reset();
        logic [7:0] addrs [3];
        addrs[0] = 8'h00;
        addrs[1] = 8'h12;
        addrs[2] = 8'hFF;
        @(negedge clk);
        #2;
        rst = 1'b1;
        for (int i = 0; i < 256; i++) model[i] = 16'h0000;
        for (int i = 0; i < 3; i++) begin
            Addr = addrs[i];
            exp_q.push_back(model[addrs[i]]);
            #1;
            exp_v = exp_q.pop_front();
            total++;
            if (O !== exp_v) begin
                bad++;
                $display("FAIL reset_read addr=%02h got=%04h exp=%04h", addrs[i], O, exp_v);
            end
        end
        #1;
        rst = 1'b0;
    endtask

    // Write one word per cycle. Each write is checked right after its edge.
    task automatic test_write_sweep();
        logic [7:0]  wa [8];
        logic [15:0] wd [8];
        wa[0] = 8'h12; wd[0] = 16'h1234;
        wa[1] = 8'h34; wd[1] = 16'h3456;
        wa[2] = 8'h56; wd[2] = 16'h5678;
        wa[3] = 8'h78; wd[3] = 16'h789A;
        wa[4] = 8'h9A; wd[4] = 16'h9ABC;
        wa[5] = 8'hBC; wd[5] = 16'hBCDE;
        wa[6] = 8'hDE; wd[6] = 16'hDEF0;
        wa[7] = 8'hF0; wd[7] = 16'hF012;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            Addr     = wa[i];
            D        = wd[i];
            Write_En = 1'b1;
            model[wa[i]] = wd[i];
            exp_q.push_back(model[wa[i]]);
            @(posedge clk);
            #1;
            exp_v = exp_q.pop_front();
            total++;
            if (O !== exp_v) begin
                bad++;
                $display("FAIL sweep_write addr=%02h got=%04h exp=%04h", wa[i], O, exp_v);
            end
        end
        @(negedge clk);
        Write_En = 1'b0;
    endtask

    // Combinational read-back: step Addr between edges with no clock edge.
    task automatic test_read_back();
        logic [7:0] ra [8];
        ra[0] = 8'h12; ra[1] = 8'h34; ra[2] = 8'h56; ra[3] = 8'h78;
        ra[4] = 8'h9A; ra[5] = 8'hBC; ra[6] = 8'hDE; ra[7] = 8'hF0;
        @(negedge clk);
        Write_En = 1'b0;
        for (int i = 0; i < 8; i++) begin
            Addr = ra[i];
            exp_q.push_back(model[ra[i]]);
            #0.5;
            exp_v = exp_q.pop_front();
            total++;
            if (O !== exp_v) begin
                bad++;
                $display("FAIL read_back addr=%02h got=%04h exp=%04h", ra[i], O, exp_v);
            end
        end
    endtask

    // Edges with Write_En low must not change memory.
    task automatic test_write_en_low();
        @(negedge clk);
        Write_En = 1'b0;
        Addr     = 8'h12;
        D        = 16'hFFFF;
        exp_q.push_back(model[8'h12]);
        repeat (3) @(posedge clk);
        #1;
        exp_v = exp_q.pop_front();
        total++;
        if (O !== exp_v) begin
            bad++;
            $display("FAIL we_low_hold addr=12 got=%04h exp=%04h", O, exp_v);
        end
        Addr = 8'h13;
        exp_q.push_back(model[8'h13]);
        #1;
        exp_v = exp_q.pop_front();
        total++;
        if (O !== exp_v) begin
            bad++;
            $display("FAIL we_low_unwritten addr=13 got=%04h exp=%04h", O, exp_v);
        end
    endtask

    // Read-during-write at the top address, then a write at the bottom
    // address. Both ends must hold their values with no aliasing.
    task automatic test_read_during_write();
        @(negedge clk);
        Addr     = 8'hFF;
        D        = 16'hA5A5;
        Write_En = 1'b1;
        exp_q.push_back(model[8'hFF]);
        #1;
        exp_v = exp_q.pop_front();
        total++;
        if (O !== exp_v) begin
            bad++;
            $display("FAIL rdw_before_edge addr=FF got=%04h exp=%04h", O, exp_v);
        end
        model[8'hFF] = 16'hA5A5;
        exp_q.push_back(model[8'hFF]);
        @(posedge clk);
        #1;
        exp_v = exp_q.pop_front();
        total++;
        if (O !== exp_v) begin
            bad++;
            $display("FAIL rdw_after_edge addr=FF got=%04h exp=%04h", O, exp_v);
        end
        @(negedge clk);
        Addr = 8'h00;
        D    = 16'h5A5A;
        model[8'h00] = 16'h5A5A;
        @(posedge clk);
        #1;
        Write_En = 1'b0;
        for (int i = 0; i < 2; i++) begin
            Addr = (i == 0) ? 8'hFF : 8'h00;
            exp_q.push_back(model[Addr]);
            #1;
            exp_v = exp_q.pop_front();
            total++;
            if (O !== exp_v) begin
                bad++;
                $display("FAIL boundary_hold addr=%02h got=%04h exp=%04h", Addr, O, exp_v);
            end
        end
    endtask

    // Reset held across an edge while a write is pending. Memory is cleared
    // and the write is dropped.
    task automatic test_reset_mid_op();
        logic [7:0] ca [11];
        ca[0] = 8'h12; ca[1] = 8'h34; ca[2] = 8'h56; ca[3] = 8'h78;
        ca[4] = 8'h9A; ca[5] = 8'hBC; ca[6] = 8'hDE; ca[7] = 8'hF0;
        ca[8] = 8'hFF; ca[9] = 8'h00; ca[10] = 8'h13;
        @(negedge clk);
        Write_En = 1'b1;
        Addr     = 8'h34;
        D        = 16'h1111;
        rst      = 1'b1;
        for (int i = 0; i < 256; i++) model[i] = 16'h0000;
        @(posedge clk);
        @(negedge clk);
        rst      = 1'b0;
        Write_En = 1'b0;
        for (int i = 0; i < 11; i++) begin
            Addr = ca[i];
            exp_q.push_back(model[ca[i]]);
            #0.5;
            exp_v = exp_q.pop_front();
            total++;
            if (O !== exp_v) begin
                bad++;
                $display("FAIL reset_mid_op addr=%02h got=%04h exp=%04h", ca[i], O, exp_v);
            end
        end
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        rst      = 1'b0;
        Addr     = 8'h00;
        Write_En = 1'b0;
        D        = 16'h0000;
        for (int i = 0; i < 256; i++) model[i] = 16'h0000;

        test_reset();
        test_write_sweep();
        test_read_back();
        test_write_en_low();
        test_read_during_write();
        test_reset_mid_op();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
